alu_simd_scheduler: RTL
=======================

ALU_SIMD_SCHEDULER -- requirements
Module: alu_simd_scheduler

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive deferrals of requester 1 before it is forced a grant.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 r0_valid / r0_ready  input / output  1 / 1  requester-0 handshake.
REQ-005 r0_wide  input  1  1 = full 45-bit op; 0 = 27-bit lane-0 op.
REQ-006 r0_w, r0_x, r0_y  input  45 each  requester-0 operands; only [26:0] used when r0_wide=0.
REQ-007 r0_cin  input  1  requester-0 carry-in; honoured only when r0_wide=1.
REQ-008 r1_valid / r1_ready  input / output  1 / 1  requester-1 handshake; always a lane-1 (18-bit) op.
REQ-009 r1_w, r1_x, r1_y  input  18 each  requester-1 operands.
REQ-010 s0_valid / s0_ready  output / input  1 / 1  requester-0 result handshake.
REQ-011 s0_data  output  45  requester-0 sum; [44:27] zero for narrow ops.
REQ-012 s1_valid / s1_ready  output / input  1 / 1  requester-1 result handshake.
REQ-013 s1_data  output  18  requester-1 sum.
REQ-014 starve_cnt  output  3  current requester-1 deferral count (debug).

Function
REQ-015 Handshake: a request is accepted in the cycle where valid and ready are both 1; results transfer when s*_valid and s*_ready are both 1.
REQ-016 Pipeline: stage A (ALU operand/mode registers), ALU combinational, stage R (result registers); accepted in cycle N -> s*_valid in cycle N+2.
REQ-017 Pairing: r0 narrow and r1 both valid -> both accepted in one issue with USE_SIMD=1, r0 on lane 0, r1 on lane 1.
REQ-018 Single narrow: only r0 narrow or only r1 valid -> issue with USE_SIMD=1, unused lane operands zero.
REQ-019 Conflict: r0 wide and r1 valid -> r0 granted (USE_SIMD=0, CIN=r0_cin) unless starve_cnt == STARVE_LIMIT, then r1 granted alone.
REQ-020 starve_cnt increments on each conflict cycle where r1 is deferred, clears on any r1 acceptance, saturates at STARVE_LIMIT.
REQ-021 Wide op alone: r0 wide and r1 invalid -> USE_SIMD=0, full 45-bit sum with carry across the 27-bit boundary.
REQ-022 result_SIMD_carry_in tied to zero; result_SIMD_carry_out ignored.
REQ-023 Stall: stage R advances only when every result it holds has been taken; while stalled, stage A holds and both r*_ready are 0.
REQ-024 r*_ready is combinational from valid inputs, grant decision and stall; a requester not granted sees ready=0.
REQ-025 Results routed by tag stored in stage A: s0_valid only for issues containing r0, s1_valid only for those containing r1; a paired issue raises both, and each clears independently on its own transfer.
REQ-026 Back-to-back: with no stall, one issue per cycle, throughput 1.
REQ-027 Overflow wraps modulo 2^45 (wide), 2^27 (lane 0), 2^18 (lane 1); no lane carry leakage in SIMD mode.

Reset
REQ-028 On reset: stage A and stage R valid bits, s0_valid, s1_valid, starve_cnt all 0; s0_data, s1_data 0.
REQ-029 Reset asserted mid-operation discards in-flight ops; no result is presented after reset release.
REQ-030 r*_ready is 0 while reset is asserted.

Structure
REQ-031 Shared package holds MODE_FULL=0, MODE_SIMD=1, lane widths 27, 18, 45, and the result-tag encoding.
REQ-032 Exactly one sub-module: ALU_T_C3x2_F0_27bits_18bits, instantiated once; arbitration, starvation counter and pipeline live in this module.

Verification
REQ-033 r0 narrow 27'h7FFFFFF+1, r1 18'h3FFFF+1 same cycle -> one SIMD issue, s0_data=0, s1_data=0 at N+2, no cross-lane carry.
REQ-034 r0 wide W=45'h7FFFFFF, X=1, cin=1, r1 idle -> s0_data=45'h8000001 at N+2 (carry crosses bit 27).
REQ-035 r0 wide held valid every cycle, r1 valid, STARVE_LIMIT=4 -> r0 granted 4 times, 5th grant to r1, starve_cnt returns to 0.
REQ-036 s1_ready=0 for 3 cycles after paired issue -> s0 transfers, pipeline stalls, r0_ready=r1_ready=0 until s1 transfers, no data lost or duplicated.
REQ-037 reset pulsed one cycle after acceptance -> s0_valid and s1_valid stay 0, starve_cnt=0, next request completes normally.
REQ-038 100 random mixed requests vs. reference model -> every result matches, order per requester preserved, no starvation beyond STARVE_LIMIT.

Source files
------------

// File: rtl/alu_simd_scheduler_pkg.sv
// alu_simd_scheduler_pkg: shared widths, ALU mode, result tags and the issue record
package alu_simd_scheduler_pkg;
  localparam int L0_W = 27;
  localparam int L1_W = 18;
  localparam int FULL_W = 45;
  typedef enum logic {MODE_FULL = 1'b0, MODE_SIMD = 1'b1} mode_e;
  typedef enum logic [1:0] {TAG_NONE = 2'b00, TAG_R0 = 2'b01, TAG_R1 = 2'b10, TAG_PAIR = 2'b11} tag_e;
  typedef struct packed {
    tag_e tag;
    mode_e mode;
    logic cin;
    logic [FULL_W-1:0] w;
    logic [FULL_W-1:0] x;
    logic [FULL_W-1:0] y;
  } issue_t;
  function automatic logic [FULL_W-1:0] lane_pack(input logic full, input logic g0, input logic g1,
                                                  input logic [FULL_W-1:0] a0, input logic [L1_W-1:0] a1);
    return full ? a0 : {a1 & {L1_W{g1}}, a0[L0_W-1:0] & {L0_W{g0}}};
  endfunction
endpackage

// File: rtl/alu_simd_scheduler_if.sv
// alu_simd_scheduler_if: request/result handshakes of the scheduler
// master = requesters/result consumers, slave = scheduler
interface alu_simd_scheduler_if;
  import alu_simd_scheduler_pkg::*;
  logic r0_valid, r0_ready, r0_wide, r0_cin;
  logic [FULL_W-1:0] r0_w, r0_x, r0_y;
  logic r1_valid, r1_ready;
  logic [L1_W-1:0] r1_w, r1_x, r1_y;
  logic s0_valid, s0_ready;
  logic [FULL_W-1:0] s0_data;
  logic s1_valid, s1_ready;
  logic [L1_W-1:0] s1_data;
  modport master(output r0_valid, r0_wide, r0_cin, r0_w, r0_x, r0_y, r1_valid, r1_w, r1_x, r1_y,
                 s0_ready, s1_ready, input r0_ready, r1_ready, s0_valid, s0_data, s1_valid, s1_data);
  modport slave(input r0_valid, r0_wide, r0_cin, r0_w, r0_x, r0_y, r1_valid, r1_w, r1_x, r1_y,
                s0_ready, s1_ready, output r0_ready, r1_ready, s0_valid, s0_data, s1_valid, s1_data);
endinterface

// File: rtl/alu_simd_scheduler_alu.sv
// ALU_T_C3x2_F0_27bits_18bits: three-operand adder, full 45-bit or split 27/18-bit lanes
// ports: use_simd, cin (full mode), simd_carry_in (lane 0), w/x/y operands, result, simd_carry_out
module ALU_T_C3x2_F0_27bits_18bits
  import alu_simd_scheduler_pkg::*;
(
  input  logic              use_simd,
  input  logic              cin,
  input  logic              simd_carry_in,
  input  logic [FULL_W-1:0] w,
  input  logic [FULL_W-1:0] x,
  input  logic [FULL_W-1:0] y,
  output logic [FULL_W-1:0] result,
  output logic              simd_carry_out
);
  logic [L0_W+1:0] lo;
  logic [L1_W+1:0] hi;
  logic [FULL_W+1:0] full;
  always_comb begin
    lo = {2'b0, w[L0_W-1:0]} + {2'b0, x[L0_W-1:0]} + {2'b0, y[L0_W-1:0]} + {{(L0_W+1){1'b0}}, simd_carry_in};
    hi = {2'b0, w[FULL_W-1:L0_W]} + {2'b0, x[FULL_W-1:L0_W]} + {2'b0, y[FULL_W-1:L0_W]};
    full = {2'b0, w} + {2'b0, x} + {2'b0, y} + {{(FULL_W+1){1'b0}}, cin};
    result = use_simd ? {hi[L1_W-1:0], lo[L0_W-1:0]} : full[FULL_W-1:0];
    simd_carry_out = use_simd ? (|lo[L0_W+1:L0_W]) | (|hi[L1_W+1:L1_W]) : |full[FULL_W+1:FULL_W];
  end
endmodule

// File: rtl/alu_simd_scheduler.sv
// alu_simd_scheduler: arbitrates two requesters onto one SIMD ALU, two-stage pipeline
// ports: clk, reset (async, active-high), bus (slave side of handshakes), starve_cnt (debug)
module alu_simd_scheduler
  import alu_simd_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  alu_simd_scheduler_if.slave bus,
  output logic [2:0] starve_cnt
);
  issue_t a_q, a_d;
  logic [2:0] starve_q, starve_d;
  logic s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
  logic [FULL_W-1:0] s0_data_q, s0_data_d, alu_res;
  logic [L1_W-1:0] s1_data_q, s1_data_d;
  logic adv, r0_full, conflict, force1, g0, g1, unused_cout;
  ALU_T_C3x2_F0_27bits_18bits u_alu (
    .use_simd(a_q.mode), .cin(a_q.cin), .simd_carry_in(1'b0),
    .w(a_q.w), .x(a_q.x), .y(a_q.y), .result(alu_res), .simd_carry_out(unused_cout)
  );
  always_comb begin
    // stage R may only be overwritten once every result it holds has been taken
    adv = !(s0_valid_q && !bus.s0_ready) && !(s1_valid_q && !bus.s1_ready);
    r0_full = bus.r0_valid && bus.r0_wide;
    conflict = r0_full && bus.r1_valid;
    force1 = conflict && starve_q == 3'(STARVE_LIMIT);
    g0 = bus.r0_valid && !force1;
    g1 = bus.r1_valid && (!r0_full || force1);
    a_d = a_q;
    if (adv) begin
      a_d.tag = tag_e'({g1, g0});
      a_d.mode = (g0 && bus.r0_wide) ? MODE_FULL : MODE_SIMD;
      a_d.cin = g0 && bus.r0_wide && bus.r0_cin;
      a_d.w = lane_pack(g0 && bus.r0_wide, g0, g1, bus.r0_w, bus.r1_w);
      a_d.x = lane_pack(g0 && bus.r0_wide, g0, g1, bus.r0_x, bus.r1_x);
      a_d.y = lane_pack(g0 && bus.r0_wide, g0, g1, bus.r0_y, bus.r1_y);
    end
    starve_d = (adv && g1) ? 3'd0 : (adv && conflict) ? starve_q + 3'd1 : starve_q;
    s0_valid_d = adv ? (a_q.tag == TAG_R0 || a_q.tag == TAG_PAIR) : s0_valid_q && !bus.s0_ready;
    s1_valid_d = adv ? (a_q.tag == TAG_R1 || a_q.tag == TAG_PAIR) : s1_valid_q && !bus.s1_ready;
    s0_data_d = adv ? (a_q.mode == MODE_SIMD ? {{L1_W{1'b0}}, alu_res[L0_W-1:0]} : alu_res) : s0_data_q;
    s1_data_d = adv ? alu_res[FULL_W-1:L0_W] : s1_data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      starve_q <= '0;
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s0_data_q <= '0;
      s1_data_q <= '0;
    end else begin
      a_q <= a_d;
      starve_q <= starve_d;
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
      s0_data_q <= s0_data_d;
      s1_data_q <= s1_data_d;
    end
  assign bus.r0_ready = !reset && adv && g0;
  assign bus.r1_ready = !reset && adv && g1;
  assign bus.s0_valid = s0_valid_q;
  assign bus.s1_valid = s1_valid_q;
  assign bus.s0_data = s0_data_q;
  assign bus.s1_data = s1_data_q;
  assign starve_cnt = starve_q;
endmodule
